display_scan_controller: RTL
============================

// Module: display_scan_controller
// PURPOSE
//  Time-multiplexes one shared seven_segment hex decoder across NUM_DIGITS common-anode digits.
//  Each digit is selected in turn, its nibble is driven to the decoder and its anode is enabled.
//  A blanking gap between digits suppresses ghosting. Display value is double-buffered
//  (load -> shadow -> active at frame boundary). Optional leading-zero suppression.
//  Sits between user logic and the shared decoder/anode pins of the board display.
// PARAMETERS
//  NUM_DIGITS       4       digits scanned; >= 2
//  TICKS_PER_DIGIT  100000  clk cycles per digit slot (BLANK + SHOW); > BLANK_TICKS
//  BLANK_TICKS      1000    cycles per slot with all anodes off; >= 1
// PORTS
//  clk          in   1             system clock, rising edge
//  rst          in   1             asynchronous, active-high reset
//  enable       in   1             1 = scan; 0 = display dark
//  lz_suppress  in   1             1 = blank leading zero digits
//  load         in   1             1-cycle strobe: capture value_in/dp_in into shadow
//  value_in     in   4*NUM_DIGITS  nibble i = digit i (digit 0 = least significant/rightmost)
//  dp_in        in   NUM_DIGITS    decimal point per digit, 1 = lit
//  hex_code     out  4             nibble to seven_segment decoder input
//  anode        out  NUM_DIGITS    active-low digit enables
//  dp_n         out  1             active-low decimal point
//  frame_start  out  1             1-cycle pulse on entry to digit 0 BLANK
//  pending      out  1             shadow holds an uncommitted load
// BEHAVIOUR
//  - All outputs registered. rst (async): anode all 1, hex_code 0, dp_n 1, frame_start 0,
//    pending 0; active/shadow regs 0; digit index 0; tick counter 0; state IDLE.
//  - States: IDLE, BLANK, SHOW. Tick counter runs 0..TICKS_PER_DIGIT-1 per slot.
//    IDLE: anode all 1, dp_n 1. If enable=1 -> BLANK, digit 0 (frame boundary).
//    BLANK: BLANK_TICKS cycles, anode all 1, dp_n 1 -> SHOW.
//    SHOW: TICKS_PER_DIGIT-BLANK_TICKS cycles, anode[d]=0 (others 1), dp_n=~dp[d] ->
//          BLANK of d+1. After d=NUM_DIGITS-1, wrap to 0 (frame boundary).
//    enable=0 in any state -> IDLE next cycle. Digit index and counter cleared.
//  - hex_code = active nibble d. It is updated on the BLANK entry edge and held stable
//    through that slot's BLANK and SHOW.
//  - Frame boundary (entry to BLANK of digit 0, from IDLE or wrap):
//    if pending, active <= shadow and pending cleared. frame_start=1 for that one cycle.
//    Frame period = NUM_DIGITS*TICKS_PER_DIGIT cycles.
//  - load: shadow <= {value_in, dp_in}; pending <= 1, registered on the next edge.
//    A repeated load before commit overwrites the shadow (last load wins).
//    load in the same cycle as commit: the commit uses the old shadow, the new data goes
//    into the shadow, and pending stays 1.
//  - Leading zero suppression: with lz_suppress=1, digit d>0 is suppressed if active
//    nibbles d..NUM_DIGITS-1 are all 0. Digit 0 is never suppressed. A suppressed digit
//    keeps its slot timing with anode all 1 and dp_n 1, even if its dp bit is set.
//  - Active value changes only at frame boundaries. A load mid-frame never tears a frame.
//  - Overlap guarantee: exactly 0 or 1 anode bit low in any cycle.
// TESTING (NUM_DIGITS=4, TICKS_PER_DIGIT=8, BLANK_TICKS=2)
//  1. Reset: assert rst between edges -> immediately anode=1111, hex_code=0, dp_n=1,
//     pending=0; all held while rst=1.
//  2. Load 16'h12AF, dp_in=0001, then enable=1 -> per 8-cycle slot: 2 cycles anode=1111,
//     then 6 cycles anode low on one digit. Order: 1110/F (dp_n=0), 1101/A, 1011/2, 0111/1.
//     Frame period 32 cycles; frame_start pulses every 32.
//  3. lz_suppress=1, value 16'h0050 -> digits 3 and 2 never have anode low; digit 1 shows 5,
//     digit 0 shows 0. Value 16'h0000 -> only anode[0] ever goes low.
//  4. Mid-frame loads 16'h1234 then 16'h5678 -> current frame unchanged; pending=1 until the
//     boundary; the next frame shows 5678; pending=0 after.
//     A load on the boundary cycle leaves pending=1.
//  5. enable=0 during digit 2 SHOW -> next cycle anode=1111, state IDLE.
//     Re-enable -> frame_start pulse, digit 0 BLANK then SHOW.
//  6. Every cycle of scenarios 2-5: at most one anode bit is 0 (assertion),
//     and hex_code never changes during SHOW.

Source files
------------

// File: rtl/display_scan_if.sv
// Bundle of the user-side controls and the display-side outputs of display_scan_controller.
// state_dbg carries the scan FSM state (0 IDLE, 1 BLANK, 2 SHOW) for observation.
interface display_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      enable;
    logic                      lz_suppress;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   value_in;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic [3:0]                hex_code;
    logic [NUM_DIGITS-1:0]     anode;
    logic                      dp_n;
    logic                      frame_start;
    logic                      pending;
    logic [1:0]                state_dbg;

    // Handshake: load is a single-cycle strobe with no back-pressure; it is always accepted
    // on the next rising edge. pending reports an accepted load not yet committed to display.
    modport master (
        output enable, lz_suppress, load, value_in, dp_in,
        input  hex_code, anode, dp_n, frame_start, pending, state_dbg
    );

    modport slave (
        input  enable, lz_suppress, load, value_in, dp_in,
        output hex_code, anode, dp_n, frame_start, pending, state_dbg
    );
endinterface

// File: rtl/display_scan_controller.sv
// Scans NUM_DIGITS common-anode digits through one shared hex decoder with a blanking gap
// per slot, a double-buffered display value and optional leading-zero suppression.
module display_scan_controller #(
    parameter int NUM_DIGITS      = 4,
    parameter int TICKS_PER_DIGIT = 100000,
    parameter int BLANK_TICKS     = 1000
) (
    input  logic           clk,
    input  logic           rst,
    display_scan_if.slave  bus
);
    localparam int DW = $clog2(NUM_DIGITS);
    localparam int TW = $clog2(TICKS_PER_DIGIT);
    localparam logic [TW-1:0] LAST_TICK  = TW'(TICKS_PER_DIGIT - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_TICKS - 1);
    localparam logic [DW-1:0] LAST_DIGIT = DW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_SHOW  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [DW-1:0]           digit_q, digit_d;
    logic [TW-1:0]           tick_q, tick_d;
    logic [4*NUM_DIGITS-1:0] active_val_q, active_val_d;
    logic [NUM_DIGITS-1:0]   active_dp_q, active_dp_d;
    logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic                    pending_q, pending_d;
    logic [3:0]              hex_q, hex_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic                    dp_n_q, dp_n_d;
    logic                    frame_start_q, frame_start_d;

    logic                    boundary;
    logic                    enter_blank;
    logic                    upper_zero;
    logic [NUM_DIGITS-1:0]   suppress;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            digit_q       <= '0;
            tick_q        <= '0;
            active_val_q  <= '0;
            active_dp_q   <= '0;
            shadow_val_q  <= '0;
            shadow_dp_q   <= '0;
            pending_q     <= 1'b0;
            hex_q         <= 4'h0;
            anode_q       <= '1;
            dp_n_q        <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            digit_q       <= digit_d;
            tick_q        <= tick_d;
            active_val_q  <= active_val_d;
            active_dp_q   <= active_dp_d;
            shadow_val_q  <= shadow_val_d;
            shadow_dp_q   <= shadow_dp_d;
            pending_q     <= pending_d;
            hex_q         <= hex_d;
            anode_q       <= anode_d;
            dp_n_q        <= dp_n_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Next-state logic: the tick counter spans the whole slot, BLANK covers its first ticks.
    always_comb begin
        state_d     = state_q;
        digit_d     = digit_q;
        tick_d      = tick_q;
        boundary    = 1'b0;
        enter_blank = 1'b0;
        if (!bus.enable) begin
            state_d = S_IDLE;
            digit_d = '0;
            tick_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d     = S_BLANK;
                    digit_d     = '0;
                    tick_d      = '0;
                    boundary    = 1'b1;
                    enter_blank = 1'b1;
                end
                S_BLANK: begin
                    tick_d = tick_q + 1'b1;
                    if (tick_q == BLANK_LAST) begin
                        state_d = S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (tick_q == LAST_TICK) begin
                        state_d     = S_BLANK;
                        tick_d      = '0;
                        enter_blank = 1'b1;
                        if (digit_q == LAST_DIGIT) begin
                            digit_d  = '0;
                            boundary = 1'b1;
                        end else begin
                            digit_d = digit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    digit_d = '0;
                    tick_d  = '0;
                end
            endcase
        end
    end

    // Commit reads the old shadow, so a load coinciding with a boundary stays pending.
    always_comb begin
        active_val_d = active_val_q;
        active_dp_d  = active_dp_q;
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        pending_d    = pending_q;
        if (boundary && pending_q) begin
            active_val_d = shadow_val_q;
            active_dp_d  = shadow_dp_q;
            pending_d    = 1'b0;
        end
        if (bus.load) begin
            shadow_val_d = bus.value_in;
            shadow_dp_d  = bus.dp_in;
            pending_d    = 1'b1;
        end
    end

    always_comb begin
        upper_zero = 1'b1;
        suppress   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_zero  = upper_zero & (active_val_d[4*i +: 4] == 4'h0);
            suppress[i] = bus.lz_suppress & upper_zero & (i != 0);
        end
    end

    // Outputs are computed from the next state so they line up with the state register.
    always_comb begin
        hex_d         = hex_q;
        anode_d       = '1;
        dp_n_d        = 1'b1;
        frame_start_d = boundary;
        if (enter_blank) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (digit_d == DW'(i)) begin
                    hex_d = active_val_d[4*i +: 4];
                end
            end
        end
        if (state_d == S_SHOW && !suppress[digit_d]) begin
            anode_d[digit_d] = 1'b0;
            dp_n_d           = ~active_dp_d[digit_d];
        end
    end

    assign bus.hex_code    = hex_q;
    assign bus.anode       = anode_q;
    assign bus.dp_n        = dp_n_q;
    assign bus.frame_start = frame_start_q;
    assign bus.pending     = pending_q;
    assign bus.state_dbg   = state_q;
endmodule
